vga_timing_gen: RTL and testbench

Parametrised VGA timing and test-pattern generator. It generalises the fixed 640x480 sync counter.
- Horizontal and vertical timing are set by parameters.
- A clock-enable input derives the pixel rate from the system clock.
- Sync polarity and colour depth are configurable, and four runtime-selectable patterns are provided.
- Sits between the board clock and the VGA DAC pins; its outputs drive the connector directly.

---
 rtl/vga_timing_gen_if.sv | 29 ++
 rtl/vga_timing_gen.sv | 176 +++++++++++++++++
 tb/tb_vga_timing_gen.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// Pixel-side signal bundle of vga_timing_gen: pixel enable and pattern select in,
// sync, colour and position out. master = generator side, slave = consumer side.
interface vga_timing_gen_if #(
    parameter int unsigned COLOR_W = 2,
    parameter int unsigned X_W     = 10,
    parameter int unsigned Y_W     = 10
) ();
    logic               pix_en;
    logic [1:0]         mode;
    logic               h_sync_pulse;
    logic               v_sync_pulse;
    logic [COLOR_W-1:0] R;
    logic [COLOR_W-1:0] G;
    logic [COLOR_W-1:0] B;
    logic               active;
    logic [X_W-1:0]     x;
    logic [Y_W-1:0]     y;
    logic               frame_start;

    modport master (
        input  pix_en, mode,
        output h_sync_pulse, v_sync_pulse, R, G, B, active, x, y, frame_start
    );

    modport slave (
        output pix_en, mode,
        input  h_sync_pulse, v_sync_pulse, R, G, B, active, x, y, frame_start
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator with registered outputs.
// Optional macro VGA_BORDER_EN forces a full-white one-pixel frame around the active area.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter bit          HSYNC_POL = 1'b0,
    parameter bit          VSYNC_POL = 1'b0,
    parameter int unsigned COLOR_W   = 2,
    parameter int unsigned X_W       = 10,
    parameter int unsigned Y_W       = 10
) (
    input  logic                clk,
    input  logic                rst,
    vga_timing_gen_if.master    vga
);
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned BAR_W   = H_ACTIVE / 8;
    localparam logic [COLOR_W-1:0] FULL = '1;

    logic [X_W-1:0]     h_cnt_q, h_cnt_d;
    logic [Y_W-1:0]     v_cnt_q, v_cnt_d;
    logic [X_W-1:0]     bar_cnt_q, bar_cnt_d;
    logic [2:0]         bar_idx_q, bar_idx_d;
    logic [1:0]         mode_q, mode_d;
    logic               hs_q, hs_d;
    logic               vs_q, vs_d;
    logic [COLOR_W-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
    logic               active_q, active_d;
    logic [X_W-1:0]     x_q, x_d;
    logic [Y_W-1:0]     y_q, y_d;
    logic               fs_q, fs_d;

    logic [31:0]        h_ext, v_ext;
    logic               at_origin, vis, h_wrap, v_wrap;
    logic [1:0]         mode_eff;
    logic [COLOR_W-1:0] pat_r, pat_g, pat_b;

    always_comb begin
        h_cnt_d   = h_cnt_q;
        v_cnt_d   = v_cnt_q;
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        mode_d    = mode_q;
        hs_d      = hs_q;
        vs_d      = vs_q;
        r_d       = r_q;
        g_d       = g_q;
        b_d       = b_q;
        active_d  = active_q;
        x_d       = x_q;
        y_d       = y_q;
        fs_d      = fs_q;

        h_ext     = 32'(h_cnt_q);
        v_ext     = 32'(v_cnt_q);
        at_origin = (h_cnt_q == '0) && (v_cnt_q == '0);
        h_wrap    = (h_ext == H_TOTAL - 1);
        v_wrap    = (v_ext == V_TOTAL - 1);
        vis       = (h_ext < H_ACTIVE) && (v_ext < V_ACTIVE);
        // The origin pixel already uses the mode being sampled, so a frame is one pattern.
        mode_eff  = at_origin ? vga.mode : mode_q;

        pat_r = '0;
        pat_g = '0;
        pat_b = '0;
        if (vis) begin
            case (mode_eff)
                2'd0: ;
                2'd1: begin
                    pat_r = bar_idx_q[2] ? FULL : '0;
                    pat_g = bar_idx_q[1] ? FULL : '0;
                    pat_b = bar_idx_q[0] ? FULL : '0;
                end
                2'd2: begin
                    pat_r = (h_cnt_q[5] ^ v_cnt_q[5]) ? FULL : '0;
                    pat_g = pat_r;
                    pat_b = pat_r;
                end
                2'd3: begin
                    pat_r = h_cnt_q[COLOR_W+4:5];
                    pat_g = v_cnt_q[COLOR_W+4:5];
                end
            endcase
`ifdef VGA_BORDER_EN
            if ((h_ext == 0) || (h_ext == H_ACTIVE - 1) ||
                (v_ext == 0) || (v_ext == V_ACTIVE - 1)) begin
                pat_r = FULL;
                pat_g = FULL;
                pat_b = FULL;
            end
`endif
        end

        if (vga.pix_en) begin
            active_d = vis;
            r_d      = pat_r;
            g_d      = pat_g;
            b_d      = pat_b;
            x_d      = h_cnt_q;
            y_d      = v_cnt_q;
            fs_d     = at_origin;
            hs_d     = ((h_ext >= H_ACTIVE + H_FP) && (h_ext < H_ACTIVE + H_FP + H_SYNC))
                       ? HSYNC_POL : ~HSYNC_POL;
            vs_d     = ((v_ext >= V_ACTIVE + V_FP) && (v_ext < V_ACTIVE + V_FP + V_SYNC))
                       ? VSYNC_POL : ~VSYNC_POL;
            if (at_origin) mode_d = vga.mode;

            // Bar index tracks h_cnt incrementally and saturates at 7 instead of dividing.
            if (h_wrap) begin
                h_cnt_d   = '0;
                bar_cnt_d = '0;
                bar_idx_d = '0;
                v_cnt_d   = v_wrap ? '0 : v_cnt_q + Y_W'(1);
            end else begin
                h_cnt_d = h_cnt_q + X_W'(1);
                if (32'(bar_cnt_q) == BAR_W - 1) begin
                    bar_cnt_d = '0;
                    if (bar_idx_q != 3'd7) bar_idx_d = bar_idx_q + 3'd1;
                end else begin
                    bar_cnt_d = bar_cnt_q + X_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
            mode_q    <= '0;
            hs_q      <= ~HSYNC_POL;
            vs_q      <= ~VSYNC_POL;
            r_q       <= '0;
            g_q       <= '0;
            b_q       <= '0;
            active_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            fs_q      <= 1'b0;
        end else begin
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
            mode_q    <= mode_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            r_q       <= r_d;
            g_q       <= g_d;
            b_q       <= b_d;
            active_q  <= active_d;
            x_q       <= x_d;
            y_q       <= y_d;
            fs_q      <= fs_d;
        end
    end

    assign vga.h_sync_pulse = hs_q;
    assign vga.v_sync_pulse = vs_q;
    assign vga.R            = r_q;
    assign vga.G            = g_q;
    assign vga.B            = b_q;
    assign vga.active       = active_q;
    assign vga.x            = x_q;
    assign vga.y            = y_q;
    assign vga.frame_start  = fs_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a reduced raster; honours VGA_BORDER_EN like the design.
module tb_vga_timing_gen;
    localparam int HA = 100, HFP = 5, HSW = 7, HBP = 8;
    localparam int VA = 70,  VFP = 3, VSW = 2, VBP = 4;
    localparam int HT = HA + HFP + HSW + HBP;
    localparam int VT = VA + VFP + VSW + VBP;
    localparam int FR = HT * VT;
    localparam int BW = HA / 8;
    localparam bit HPOL = 1'b1;
    localparam bit VPOL = 1'b0;

    typedef struct packed {
        logic       hs;
        logic       vs;
        logic [1:0] r;
        logic [1:0] g;
        logic [1:0] b;
        logic       act;
        logic [6:0] x;
        logic [6:0] y;
        logic       fs;
    } px_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    vga_timing_gen_if #(.COLOR_W(2), .X_W(7), .Y_W(7)) vif ();

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL),
        .COLOR_W(2), .X_W(7), .Y_W(7)
    ) dut (
        .clk(clk),
        .rst(rst),
        .vga(vif)
    );

    px_t        expq[$];
    px_t        last_exp;
    px_t        rst_px;
    int         total = 0;
    int         bad   = 0;
    int         n     = 0;
    logic [1:0] fm    = 2'd0;
    logic [1:0] md    = 2'd0;

    function automatic px_t model(input int k, input logic [1:0] m);
        px_t p;
        int  h, v, b;
        bit  vis;
        h = k % HT;
        v = (k / HT) % VT;
        p = '0;
        p.x   = 7'(h);
        p.y   = 7'(v);
        vis   = (h < HA) && (v < VA);
        p.act = vis;
        p.hs  = (h >= HA + HFP && h < HA + HFP + HSW) ? HPOL : !HPOL;
        p.vs  = (v >= VA + VFP && v < VA + VFP + VSW) ? VPOL : !VPOL;
        p.fs  = (h == 0) && (v == 0);
        if (vis) begin
            case (m)
                2'd1: begin
                    b = h / BW;
                    if (b > 7) b = 7;
                    p.r = (b & 4) != 0 ? 2'd3 : 2'd0;
                    p.g = (b & 2) != 0 ? 2'd3 : 2'd0;
                    p.b = (b & 1) != 0 ? 2'd3 : 2'd0;
                end
                2'd2: begin
                    p.r = (((h / 32) + (v / 32)) % 2 == 1) ? 2'd3 : 2'd0;
                    p.g = p.r;
                    p.b = p.r;
                end
                2'd3: begin
                    p.r = 2'((h / 32) % 4);
                    p.g = 2'((v / 32) % 4);
                end
                default: ;
            endcase
`ifdef VGA_BORDER_EN
            if (h == 0 || h == HA - 1 || v == 0 || v == VA - 1) begin
                p.r = 2'd3;
                p.g = 2'd3;
                p.b = 2'd3;
            end
`endif
        end
        return p;
    endfunction

    function automatic px_t cur();
        px_t p;
        p.hs  = vif.h_sync_pulse;
        p.vs  = vif.v_sync_pulse;
        p.r   = vif.R;
        p.g   = vif.G;
        p.b   = vif.B;
        p.act = vif.active;
        p.x   = vif.x;
        p.y   = vif.y;
        p.fs  = vif.frame_start;
        return p;
    endfunction

    task automatic check(input string name, input px_t act, input px_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s t=%0t x=%0d exp_x=%0d y=%0d exp_y=%0d got=%h exp=%h",
                     name, $time, act.x, exp.x, act.y, exp.y, act, exp);
        end
    endtask

    // One clock of stimulus; an enabled edge pushes the model's pixel for that edge.
    task automatic step(input bit en);
        int h, v;
        @(negedge clk);
        vif.pix_en = en;
        vif.mode   = md;
        if (en) begin
            h = n % HT;
            v = (n / HT) % VT;
            if (h == 0 && v == 0) fm = md;
            expq.push_back(model(n, fm));
            n++;
        end
    endtask

    task automatic do_reset();
        step(1'b0);
        step(1'b0);
        #2 rst = 1'b1;
        last_exp = rst_px;
        #1 check("async_rst", cur(), rst_px);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n   = 0;
    endtask

    // Monitor: after every edge, pop on an enabled edge, otherwise expect a hold.
    initial begin : monitor
        bit en_s, rst_s;
        forever begin
            @(posedge clk);
            en_s  = vif.pix_en;
            rst_s = rst;
            #1;
            if (en_s && !rst_s) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL sb_empty t=%0t got=%h exp=queued_pixel", $time, cur());
                end else begin
                    last_exp = expq.pop_front();
                    check("pixel", cur(), last_exp);
                end
            end else begin
                check("hold", cur(), last_exp);
            end
        end
    end

    initial begin : stimulus
        bit hit;
        rst_px    = '0;
        rst_px.hs = !HPOL;
        rst_px.vs = !VPOL;
        last_exp  = rst_px;
        vif.pix_en = 1'b0;
        vif.mode   = 2'd0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Colour bars, pixel enable every clock, slightly more than one frame.
        md = 2'd1;
        for (int i = 0; i < FR + HT; i++) step(1'b1);

        // Pixel enable on every 4th clock, occasional mode changes.
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 499) == 0) md = 2'($urandom_range(0, 3));
            step(i % 4 == 0);
        end

        // Random pixel enable and random mid-frame mode changes.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 199) == 0) md = 2'($urandom_range(0, 3));
            step($urandom_range(0, 9) < 7);
        end

        // Run into the vertical sync region, then reset asynchronously.
        hit = 1'b0;
        for (int i = 0; i < 3 * FR && !hit; i++) begin
            step($urandom_range(0, 9) < 8);
            if (n > 0 && ((n - 1) % HT) == 30 && ((n - 1) / HT) % VT == VA + VFP) hit = 1'b1;
        end
        if (!hit) begin
            total++;
            bad++;
            $display("FAIL vsync_reach got=not_reached exp=reached");
        end
        step(1'b0);
        do_reset();

        // Checkerboard, then a mid-frame switch to gradient that lands on the next frame.
        md = 2'd2;
        for (int i = 0; i < FR / 2; i++) step(1'b1);
        md = 2'd3;
        for (int i = 0; i < FR; i++) step(1'b1);
        md = 2'd0;
        for (int i = 0; i < 200; i++) step(1'b1);

        step(1'b0);
        step(1'b0);
        step(1'b0);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL sb_drain got=%0d exp=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
